traffic_sensor_ctrl: RTL and testbench
======================================

Name: traffic_sensor_ctrl

Overview:
- Front end for the two-street traffic light controller.
- Conditions raw loop-detector and parade-button inputs, and tracks cars queued per street using light feedback.
- Produces the controller's TA, TB, P and R inputs.
- Sits between the pad-level sensors and the light FSM, so it is the producer side of the FSM's sensor interface.

Parameters:
- DEB_CYC, 4, consecutive stable synchronized samples required before a debounced level changes (min 1).
- PASS_CYC, 8, green cycles per departing car.
- CNT_W, 4, queue counter width; saturates at 2^CNT_W-1.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_car_a  in  1  raw street-A detector; asynchronous, bouncy.
- i_car_b  in  1  raw street-B detector; asynchronous, bouncy.
- i_parade_req  in  1  raw parade-start button; asynchronous.
- i_parade_end  in  1  raw parade-end button; asynchronous.
- i_LA  in  2  street-A light fed back from the FSM: 0 GREEN, 1 YELLOW, 2 RED, 3 treated as RED.
- i_LB  in  2  street-B light, same encoding.
- o_TA  out  1  street-A traffic present: cnt_A != 0.
- o_TB  out  1  street-B traffic present: cnt_B != 0.
- o_P  out  1  parade-start strobe, one cycle.
- o_R  out  1  parade-end strobe, one cycle.
- o_cnt_A  out  CNT_W  street-A queue count.
- o_cnt_B  out  CNT_W  street-B queue count.
- o_ovf  out  1  sticky; set when an arrival hits a saturated counter.

Behaviour:
- Reset (async assert, sync deassert): all sync flops, debounced levels, counters, timers and o_ovf go to 0; parade FSM goes to IDLE. So o_TA=o_TB=o_P=o_R=0 and counts are 0. Reset mid-operation discards all queued cars and any pending strobe.
- Input conditioning, per raw input: 2-flop synchronizer, then a debouncer.
  - The stable counter clears whenever the synchronized value differs from the debounced level.
  - The debounced level flips once the synchronized value has differed for DEB_CYC consecutive cycles.
  - Glitches shorter than DEB_CYC cycles are ignored.
- Arrival: a debounced rising edge of i_car_x increments cnt_x on the next edge.
  - Total latency from the first edge sampling raw high to the updated count is 2+DEB_CYC cycles (6 at default).
  - The falling edge has no effect.
- Departure timer, per street:
  - Clears to 0 whenever the street's light is not GREEN or cnt_x==0.
  - Otherwise it counts up. When it reaches PASS_CYC-1, cnt_x decrements and the timer returns to 0.
  - First departure occurs PASS_CYC cycles after green with cars queued.
- Simultaneous arrival and departure in the same cycle: cnt_x unchanged.
- Arrival at saturation (2^CNT_W-1): count holds and o_ovf sets. o_ovf clears only on reset.
- Departure at cnt_x==0 cannot occur (timer held clear). Count never underflows.
- o_TA/o_TB are combinational compares of the count registers; no extra delay.
- Parade FSM, states IDLE and ACTIVE:
  - IDLE: a debounced rising edge of parade_req pulses o_P for one cycle and moves to ACTIVE. parade_end edges are ignored.
  - ACTIVE: a debounced rising edge of parade_end pulses o_R for one cycle and moves to IDLE. parade_req edges are ignored.
  - Both edges in the same cycle: only the edge valid for the current state acts.
  - o_P and o_R are registered and never both high.
- Light codes 1, 2 and 3 all count as not-green.

Optional Feature:
- TRAFFIC_SENSOR_STAT_EN
- Defined: adds outputs o_total_A and o_total_B (16 bits each).
  - Each counts every accepted arrival on its street, including arrivals that hit saturation.
  - Each wraps 0xFFFF->0 without a flag.
  - Both reset to 0.
- Undefined: the ports and logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset with i_rst=1 mid-run, cnt_A=5, o_P just issued -> o_TA=0, o_cnt_A=0, o_P=0, FSM IDLE on the same edge; after release a new parade_req produces o_P again.
- i_car_a pulse high for 3 cycles, then 10 cycles clean high, i_LA=RED -> the 3-cycle glitch is ignored; o_cnt_A=1 and o_TA=1 exactly 6 cycles after the clean rise.
- cnt_B=3, i_LB switches to GREEN -> o_cnt_B goes 2, 1, 0 at 8, 16 and 24 cycles after the switch. o_TB falls with the last decrement. Switching i_LB to YELLOW at cycle 12 freezes the count at 2.
- i_LA=GREEN with cnt_A=2; an arrival edge lands in the same cycle as a departure -> o_cnt_A stays 2.
- 16 arrivals on A with CNT_W=4 and i_LA=RED -> o_cnt_A=15, o_ovf=1 after the 16th; with TRAFFIC_SENSOR_STAT_EN, o_total_A=16.
- parade_req, then a second parade_req, then parade_end, then a second parade_end -> exactly one o_P then one o_R, each one cycle wide; the repeated presses produce nothing.

Source files
------------

// File: rtl/traffic_sensor_ctrl.sv
// Purpose : sensor front end for the two-street light FSM; conditions raw detector/button pads into TA/TB/P/R.
// Latency : raw rising edge -> count/strobe update after 2+DEB_CYC clocks; o_TA/o_TB follow the counts combinationally.
// Backpress: none; producer-only interface, inputs are sampled every clock and the FSM has no ready path.
//
// Ports:
//   i_clk, i_rst          clock (rising edge) and asynchronous active-high reset
//   i_car_a, i_car_b      raw bouncy loop detectors, one per street
//   i_parade_req/_end     raw parade start/end buttons
//   i_LA, i_LB            light feedback: 0 GREEN, 1 YELLOW, 2/3 RED
//   o_TA, o_TB            traffic present (queue count non-zero)
//   o_P, o_R              one-cycle parade start / end strobes
//   o_cnt_A, o_cnt_B      per-street queue counts (saturating)
//   o_ovf                 sticky overflow, an arrival hit a saturated count
//   o_total_A/B           16-bit wrapping arrival totals, only with TRAFFIC_SENSOR_STAT_EN defined
module traffic_sensor_ctrl #(
  parameter int DEB_CYC  = 4,
  parameter int PASS_CYC = 8,
  parameter int CNT_W    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_car_a,
  input  logic             i_car_b,
  input  logic             i_parade_req,
  input  logic             i_parade_end,
  input  logic [1:0]       i_LA,
  input  logic [1:0]       i_LB,
  output logic             o_TA,
  output logic             o_TB,
  output logic             o_P,
  output logic             o_R,
  output logic [CNT_W-1:0] o_cnt_A,
  output logic [CNT_W-1:0] o_cnt_B,
  output logic             o_ovf
`ifdef TRAFFIC_SENSOR_STAT_EN
  ,
  output logic [15:0]      o_total_A,
  output logic [15:0]      o_total_B
`endif
);

  localparam int DCW = $clog2(DEB_CYC + 1);
  localparam int TW  = (PASS_CYC > 1) ? $clog2(PASS_CYC) : 1;
  localparam logic [DCW-1:0]   DEB_LAST = DCW'(DEB_CYC - 1);
  localparam logic [TW-1:0]    TMR_LAST = TW'(PASS_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Reset: asserted asynchronously, released on a clock edge so no flop
  // sees the release close to its sampling edge.
  logic [1:0] rst_pipe;
  logic       rst_int;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) rst_pipe <= 2'b11;
    else       rst_pipe <= {rst_pipe[0], 1'b0};
  end

  assign rst_int = rst_pipe[1];

  // Input conditioning. Channel order: 0 car_a, 1 car_b, 2 parade_req, 3 parade_end.
  logic [3:0]     raw;
  logic [3:0]     meta;
  logic [3:0]     sync;
  logic [3:0]     deb;
  logic [3:0]     deb_q;
  logic [3:0]     rise;
  logic [DCW-1:0] stab [4];

  assign raw = {i_parade_end, i_parade_req, i_car_b, i_car_a};

  always_ff @(posedge i_clk or posedge rst_int) begin
    if (rst_int) begin
      meta  <= '0;
      sync  <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < 4; i++) stab[i] <= '0;
    end else begin
      meta  <= raw;
      sync  <= meta;
      deb_q <= deb;
      for (int i = 0; i < 4; i++) begin
        // stab counts consecutive cycles the synced value disagrees with
        // the debounced level; any agreement restarts the count.
        if (sync[i] == deb[i]) begin
          stab[i] <= '0;
        end else if (stab[i] == DEB_LAST) begin
          stab[i] <= '0;
          deb[i]  <= sync[i];
        end else begin
          stab[i] <= stab[i] + DCW'(1);
        end
      end
    end
  end

  assign rise = deb & ~deb_q;

  // Per-street queue counters and departure timers. Index 0 = A, 1 = B.
  logic [CNT_W-1:0] cnt [2];
  logic [TW-1:0]    tmr [2];
  logic [1:0]       green;
  logic [1:0]       arr;
  logic [1:0]       dep;
  logic             ovf;

  assign green[0] = (i_LA == 2'd0);
  assign green[1] = (i_LB == 2'd0);
  assign arr      = rise[1:0];

  always_comb begin
    dep = '0;
    for (int s = 0; s < 2; s++) begin
      dep[s] = green[s] && (cnt[s] != '0) && (tmr[s] == TMR_LAST);
    end
  end

  always_ff @(posedge i_clk or posedge rst_int) begin
    if (rst_int) begin
      for (int s = 0; s < 2; s++) begin
        cnt[s] <= '0;
        tmr[s] <= '0;
      end
      ovf <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        // Timer only runs while cars can actually leave.
        if (!green[s] || (cnt[s] == '0) || dep[s]) tmr[s] <= '0;
        else                                      tmr[s] <= tmr[s] + TW'(1);

        // Arrival and departure in the same cycle cancel out.
        case ({arr[s], dep[s]})
          2'b10: begin
            if (cnt[s] == CNT_MAX) ovf <= 1'b1;
            else                   cnt[s] <= cnt[s] + CNT_W'(1);
          end
          2'b01:   cnt[s] <= cnt[s] - CNT_W'(1);
          default: ;
        endcase
      end
    end
  end

  assign o_cnt_A = cnt[0];
  assign o_cnt_B = cnt[1];
  assign o_TA    = (cnt[0] != '0);
  assign o_TB    = (cnt[1] != '0);
  assign o_ovf   = ovf;

`ifdef TRAFFIC_SENSOR_STAT_EN
  // Totals include arrivals dropped at saturation; wrap silently.
  logic [15:0] tot [2];

  always_ff @(posedge i_clk or posedge rst_int) begin
    if (rst_int) begin
      tot[0] <= '0;
      tot[1] <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (arr[s]) tot[s] <= tot[s] + 16'd1;
      end
    end
  end

  assign o_total_A = tot[0];
  assign o_total_B = tot[1];
`endif

  // Parade FSM: each state only listens to the one button that can leave it.
  typedef enum logic {
    PARADE_IDLE   = 1'b0,
    PARADE_ACTIVE = 1'b1
  } parade_state_t;

  parade_state_t state_q;
  parade_state_t state_d;
  logic          p_q;
  logic          p_d;
  logic          r_q;
  logic          r_d;

  always_ff @(posedge i_clk or posedge rst_int) begin
    if (rst_int) begin
      state_q <= PARADE_IDLE;
      p_q     <= 1'b0;
      r_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      r_q     <= r_d;
    end
  end

  always_comb begin
    state_d = state_q;
    p_d     = 1'b0;
    r_d     = 1'b0;
    case (state_q)
      PARADE_IDLE: begin
        if (rise[2]) begin
          p_d     = 1'b1;
          state_d = PARADE_ACTIVE;
        end
      end
      PARADE_ACTIVE: begin
        if (rise[3]) begin
          r_d     = 1'b1;
          state_d = PARADE_IDLE;
        end
      end
      default: state_d = PARADE_IDLE;
    endcase
  end

  assign o_P = p_q;
  assign o_R = r_q;

endmodule

// File: tb/tb_traffic_sensor_ctrl.sv
// Purpose : self-checking bench for traffic_sensor_ctrl; directed scenarios then random pad activity.
// Latency : reference model predicts every output after each clock edge.
// Backpress: not applicable; stimulus is free-running.
module tb_traffic_sensor_ctrl;

  localparam int DEB  = 4;
  localparam int PASS = 8;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [3:0]    raw = 4'b0000;   // 0 car_a, 1 car_b, 2 parade_req, 3 parade_end
  logic [1:0]    la  = 2'd2;
  logic [1:0]    lb  = 2'd2;
  logic          o_ta, o_tb, o_p, o_r, o_ovf;
  logic [CW-1:0] o_cnt_a, o_cnt_b;
`ifdef TRAFFIC_SENSOR_STAT_EN
  logic [15:0]   o_total_a, o_total_b;
`endif

  traffic_sensor_ctrl #(.DEB_CYC(DEB), .PASS_CYC(PASS), .CNT_W(CW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_car_a      (raw[0]),
    .i_car_b      (raw[1]),
    .i_parade_req (raw[2]),
    .i_parade_end (raw[3]),
    .i_LA         (la),
    .i_LB         (lb),
    .o_TA         (o_ta),
    .o_TB         (o_tb),
    .o_P          (o_p),
    .o_R          (o_r),
    .o_cnt_A      (o_cnt_a),
    .o_cnt_B      (o_cnt_b),
    .o_ovf        (o_ovf)
`ifdef TRAFFIC_SENSOR_STAT_EN
    ,
    .o_total_A    (o_total_a),
    .o_total_B    (o_total_b)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int rst_hold = 0;
  int p_seen = 0;
  int r_seen = 0;

  // Reference model state.
  int m_cnt [2];
  int m_tmr [2];
  int m_tot [2];
  bit m_ovf, m_p, m_r, m_act;
  bit lvl [4];
  int run [4];
  bit ev [4][8];   // pending debounced rising edges, indexed by edge number mod 8

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int s = 0; s < 2; s++) begin
      m_cnt[s] = 0;
      m_tmr[s] = 0;
      m_tot[s] = 0;
    end
    m_ovf = 0; m_p = 0; m_r = 0; m_act = 0;
    for (int c = 0; c < 4; c++) begin
      lvl[c] = 0;
      run[c] = 0;
      for (int k = 0; k < 8; k++) ev[c][k] = 0;
    end
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  // A raw level that differs from the debounced level for DEB consecutive
  // samples is accepted; a rising acceptance takes effect 3 edges later
  // (2 synchronizer stages plus the edge-detect register).
  task automatic model_step();
    bit fire [4];
    int slot;
    bit dep, green;
    logic [1:0] light;
    if (rst) begin
      model_clear();
      rst_hold = 2;
      return;
    end
    if (rst_hold > 0) begin
      model_clear();
      rst_hold--;
      return;
    end
    slot = edge_n % 8;
    for (int c = 0; c < 4; c++) begin
      fire[c] = ev[c][slot];
      ev[c][slot] = 0;
    end
    for (int c = 0; c < 4; c++) begin
      if (raw[c] != lvl[c]) run[c]++;
      else                  run[c] = 0;
      if (run[c] == DEB) begin
        lvl[c] = !lvl[c];
        run[c] = 0;
        if (lvl[c]) ev[c][(edge_n + 3) % 8] = 1;
      end
    end
    for (int s = 0; s < 2; s++) begin
      light = (s == 0) ? la : lb;
      green = (light == 2'd0);
      dep   = green && (m_cnt[s] > 0) && (m_tmr[s] == PASS - 1);
      if (!green || m_cnt[s] == 0 || dep) m_tmr[s] = 0;
      else                                m_tmr[s]++;
      if (fire[s]) m_tot[s] = (m_tot[s] + 1) % 65536;
      if (fire[s] && !dep) begin
        if (m_cnt[s] == CMAX) m_ovf = 1;
        else                  m_cnt[s]++;
      end else if (dep && !fire[s]) begin
        m_cnt[s]--;
      end
    end
    m_p = 0;
    m_r = 0;
    if (!m_act && fire[2]) begin
      m_p = 1;
      m_act = 1;
    end else if (m_act && fire[3]) begin
      m_r = 1;
      m_act = 0;
    end
  endtask

  task automatic check_all();
    check("cnt_A", 32'(o_cnt_a), 32'(m_cnt[0]));
    check("cnt_B", 32'(o_cnt_b), 32'(m_cnt[1]));
    check("TA", 32'(o_ta), 32'(m_cnt[0] != 0));
    check("TB", 32'(o_tb), 32'(m_cnt[1] != 0));
    check("P", 32'(o_p), 32'(m_p));
    check("R", 32'(o_r), 32'(m_r));
    check("ovf", 32'(o_ovf), 32'(m_ovf));
`ifdef TRAFFIC_SENSOR_STAT_EN
    check("total_A", 32'(o_total_a), 32'(m_tot[0]));
    check("total_B", 32'(o_total_b), 32'(m_tot[1]));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    model_step();
    #1;
    check_all();
    p_seen += int'(o_p);
    r_seen += int'(o_r);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input int ch, input int hi, input int lo);
    raw[ch] = 1'b1;
    tick_n(hi);
    raw[ch] = 1'b0;
    tick_n(lo);
  endtask

  task automatic do_reset();
    raw = 4'b0000;
    rst = 1'b1;
    model_clear();
    tick_n(3);
    rst = 1'b0;
    tick_n(4);
  endtask

  initial begin
    model_clear();
    // Power-on reset; check the asynchronous clear before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_TA", 32'(o_ta), 32'd0);
    check("rst_cnt_A", 32'(o_cnt_a), 32'd0);
    check("rst_P", 32'(o_p), 32'd0);
    check("rst_R", 32'(o_r), 32'd0);
    check("rst_ovf", 32'(o_ovf), 32'd0);
    tick_n(3);
    rst = 1'b0;
    tick_n(4);

    // Short glitch ignored, clean rise counted 6 edges after first sample.
    la = 2'd2;
    pulse(0, 3, 3);
    raw[0] = 1'b1;
    tick_n(6);
    check("glitch_cnt_pre", 32'(o_cnt_a), 32'd0);
    tick_n(1);
    check("arrive_cnt", 32'(o_cnt_a), 32'd1);
    check("arrive_TA", 32'(o_ta), 32'd1);
    tick_n(3);
    raw[0] = 1'b0;
    tick_n(8);

    // Street B drains 3 cars at 8, 16, 24 edges after going green.
    lb = 2'd2;
    for (int i = 0; i < 3; i++) pulse(1, 6, 6);
    check("fill_B", 32'(o_cnt_b), 32'd3);
    lb = 2'd0;
    tick_n(7);  check("drain_7", 32'(o_cnt_b), 32'd3);
    tick_n(1);  check("drain_8", 32'(o_cnt_b), 32'd2);
    tick_n(7);  check("drain_15", 32'(o_cnt_b), 32'd2);
    tick_n(1);  check("drain_16", 32'(o_cnt_b), 32'd1);
    tick_n(8);  check("drain_24", 32'(o_cnt_b), 32'd0);
    check("drain_TB", 32'(o_tb), 32'd0);
    lb = 2'd2;
    for (int i = 0; i < 3; i++) pulse(1, 6, 6);
    lb = 2'd0;
    tick_n(12);
    lb = 2'd1;
    tick_n(20);
    check("yellow_freeze", 32'(o_cnt_b), 32'd2);
    lb = 2'd2;

    // Arrival and departure on the same edge leave the count unchanged.
    pulse(0, 6, 6);
    check("fill_A2", 32'(o_cnt_a), 32'd2);
    la = 2'd0;
    tick_n(1);
    raw[0] = 1'b1;
    tick_n(6);
    check("simul_pre", 32'(o_cnt_a), 32'd2);
    tick_n(1);
    check("simul_same", 32'(o_cnt_a), 32'd2);
    raw[0] = 1'b0;
    tick_n(8);
    check("simul_next_dep", 32'(o_cnt_a), 32'd1);
    la = 2'd2;

    // Saturation and sticky overflow.
    do_reset();
    for (int i = 0; i < 15; i++) pulse(0, 6, 6);
    check("sat15_cnt", 32'(o_cnt_a), 32'd15);
    check("sat15_ovf", 32'(o_ovf), 32'd0);
    pulse(0, 6, 6);
    check("sat16_cnt", 32'(o_cnt_a), 32'd15);
    check("sat16_ovf", 32'(o_ovf), 32'd1);
`ifdef TRAFFIC_SENSOR_STAT_EN
    check("sat16_total", 32'(o_total_a), 32'd16);
`endif

    // Parade: repeated presses in the wrong state do nothing.
    do_reset();
    p_seen = 0;
    r_seen = 0;
    pulse(2, 6, 10);
    pulse(2, 6, 10);
    pulse(3, 6, 10);
    pulse(3, 6, 10);
    check("parade_P_count", 32'(p_seen), 32'd1);
    check("parade_R_count", 32'(r_seen), 32'd1);

    // Reset mid-run right after a parade strobe.
    la = 2'd2;
    for (int i = 0; i < 5; i++) pulse(0, 6, 6);
    check("mid_cnt5", 32'(o_cnt_a), 32'd5);
    raw[2] = 1'b1;
    tick_n(6);
    raw[2] = 1'b0;
    tick_n(1);
    check("mid_P_issued", 32'(o_p), 32'd1);
    rst = 1'b1;
    model_clear();
    #1;
    check("mid_rst_TA", 32'(o_ta), 32'd0);
    check("mid_rst_cnt", 32'(o_cnt_a), 32'd0);
    check("mid_rst_P", 32'(o_p), 32'd0);
    check("mid_rst_ovf", 32'(o_ovf), 32'd0);
    tick_n(3);
    rst = 1'b0;
    tick_n(4);
    raw[2] = 1'b1;
    tick_n(6);
    raw[2] = 1'b0;
    tick_n(1);
    check("post_rst_P", 32'(o_p), 32'd1);
    tick_n(1);
    check("post_rst_P_width", 32'(o_p), 32'd0);

    // Random pad activity (bounces, glitches, light changes) against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) raw[0] = ~raw[0];
      if ($urandom_range(3) == 0) raw[1] = ~raw[1];
      if ($urandom_range(5) == 0) raw[2] = ~raw[2];
      if ($urandom_range(5) == 0) raw[3] = ~raw[3];
      if ($urandom_range(19) == 0) la = ($urandom_range(1) == 0) ? 2'd0 : 2'($urandom_range(3));
      if ($urandom_range(19) == 0) lb = ($urandom_range(1) == 0) ? 2'd0 : 2'($urandom_range(3));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
